combat_state_tracker: RTL and testbench
=======================================

# combat_state_tracker

Parametrised per-frame health, guard and stun bookkeeping for two fighters, with round and match sequencing. Runs on the game-frame clock. Consumes registered hit/block events from the hit-detection logic and drives the HUD, the character FSMs (stun flags and timers) and the top-level game FSM (round and match results).

## Interface
- MAX_HEALTH, 3: health at round start (1..2^HEALTH_W-1)
- HEALTH_W, 3: width of health counters
- MAX_BLOCKS, 3: guard charges at round start
- BLOCK_W, 3: width of block counters
- DAMAGE, 1: health lost per hit
- HITSTUN, 16: hitstun reload value
- BLOCKSTUN, 14: blockstun reload value
- STUN_W, 5: stun timer width
- REGEN_FRAMES, 120: event-free frames before one guard charge regenerates (0 disables regeneration)
- ROUNDS_TO_WIN, 2: round wins that end the match
- clk_game  in  1  frame clock
- reset  in  1  asynchronous, active-high
- game_active  in  1  freeze when low (inputs ignored, all state held)
- round_start  in  1  one-frame pulse that starts or restarts a round
- p1_hit_p2, p2_hit_p1, p1_blocked_by_p2, p2_blocked_by_p1  in  1 each  one-frame event pulses
- p1_health, p2_health  out  HEALTH_W
- p1_block_count, p2_block_count  out  BLOCK_W
- p1_in_hitstun, p2_in_hitstun, p1_in_blockstun, p2_in_blockstun  out  1 each
- p1_stun_timer, p2_stun_timer  out  STUN_W
- p1_rounds, p2_rounds  out  2
- round_over  out  1
- round_winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- match_over  out  1
- match_winner  out  2  same encoding as round_winner

## Operation
- FSM states: IDLE, FIGHT, ROUND_END, MATCH_END. The FSM only advances when game_active=1.
- IDLE: round_start moves to FIGHT and loads round state. Round state is health=MAX_HEALTH, blocks=MAX_BLOCKS, stun flags/timers=0, regen counters=0.
- FIGHT: event processing per player. Described for P1; P2 is symmetric.
  - p2_hit_p1: health -= DAMAGE, saturating at 0. Load timer=HITSTUN, set hitstun, clear blockstun.
  - p2_blocked_by_p1 with block_count>0: block_count -= 1. Load timer=BLOCKSTUN, set blockstun, clear hitstun.
  - p2_blocked_by_p1 with block_count==0 (guard break): handled exactly as a hit.
  - Hit and block on the same player in the same frame: the hit takes priority and the block count is unchanged.
  - No event, stun flag set: timer>0 decrements. timer==0 clears both flags. Each stun flag is therefore high for reload+1 frames.
  - Regeneration: the regen counter increments on frames with no event on that player while block_count<MAX_BLOCKS. It clears on any event. Reaching REGEN_FRAMES adds one charge and clears the counter.
- FIGHT to ROUND_END: on the frame after either health register reads 0. At the transition:
  - round_winner latches: 01 if P2 is at 0, 10 if P1 is at 0, 11 if both are 0 (simultaneous trade).
  - The winner's round count increments. A draw increments neither.
- ROUND_END: round_over=1, and further events are ignored.
  - If the incremented count equals ROUNDS_TO_WIN, go to MATCH_END on the next frame, with match_winner set to that player.
  - Otherwise round_start reloads round state, clears round_winner and returns to FIGHT.
- MATCH_END: match_over=1 and round_over stays 1.
  - round_start clears the round counts and match_winner, reloads round state and enters FIGHT.

## Timing
- Reset values:
  - State IDLE.
  - health=MAX_HEALTH, blocks=MAX_BLOCKS.
  - All stun flags, timers, round counts, winners, round_over and match_over at 0.
- All outputs are registered. An event in frame N is visible at the clk_game edge ending frame N (one-frame latency).
- round_over rises one frame after the health register reaches 0.
- match_over rises one frame after round_over when the match is decided.
- Stun timers never underflow. Health and block counters never wrap below 0 or exceed their maximum.
- An event during a frame with game_active=0 is lost, not queued.
- Reset asserted mid-round returns every output to its reset value asynchronously.
- round_start while in FIGHT is ignored.

## Test plan
- Reset, round_start, then three p1_hit_p2 pulses spaced 20 frames apart:
  - p2_health goes 3→2→1→0.
  - round_over goes high 1 frame after reaching 0, with round_winner=01 and p1_rounds=1.
- Single p2_hit_p1:
  - p1_in_hitstun is high for exactly 17 frames.
  - p1_stun_timer counts 16..0.
- Four p1_blocked_by_p2 pulses 20 frames apart:
  - p2_block_count goes 3→2→1→0.
  - The fourth pulse is a guard break: p2_health 3→2 and p2_in_hitstun is set.
- REGEN_FRAMES=8, after one block (count=2) and no further events:
  - count returns to 3 nine frames later.
  - A block arriving on frame 7 restarts the regen count.
- Simultaneous p1_hit_p2 and p2_hit_p1 with both players at health 1: round_winner=11 and both round counts remain 0.
- ROUNDS_TO_WIN=2:
  - After P1's second round win, match_over=1 and match_winner=01.
  - round_start then clears the round counts, and the state is FIGHT with health=3.

Source files
------------

// File: rtl/combat_state_tracker_if.sv
// Event inputs and HUD/FSM status outputs of the combat state tracker.
// Latency: n/a (wires only).
// Backpressure: none; events are single-frame pulses, status is level.
interface combat_state_tracker_if #(
    parameter int HEALTH_W = 3,
    parameter int BLOCK_W  = 3,
    parameter int STUN_W   = 5
);
    logic                game_active;
    logic                round_start;
    logic                p1_hit_p2;
    logic                p2_hit_p1;
    logic                p1_blocked_by_p2;
    logic                p2_blocked_by_p1;
    logic [HEALTH_W-1:0] p1_health;
    logic [HEALTH_W-1:0] p2_health;
    logic [BLOCK_W-1:0]  p1_block_count;
    logic [BLOCK_W-1:0]  p2_block_count;
    logic                p1_in_hitstun;
    logic                p2_in_hitstun;
    logic                p1_in_blockstun;
    logic                p2_in_blockstun;
    logic [STUN_W-1:0]   p1_stun_timer;
    logic [STUN_W-1:0]   p2_stun_timer;
    logic [1:0]          p1_rounds;
    logic [1:0]          p2_rounds;
    logic                round_over;
    logic [1:0]          round_winner;
    logic                match_over;
    logic [1:0]          match_winner;

    modport master (
        output game_active, round_start, p1_hit_p2, p2_hit_p1,
               p1_blocked_by_p2, p2_blocked_by_p1,
        input  p1_health, p2_health, p1_block_count, p2_block_count,
               p1_in_hitstun, p2_in_hitstun, p1_in_blockstun, p2_in_blockstun,
               p1_stun_timer, p2_stun_timer, p1_rounds, p2_rounds,
               round_over, round_winner, match_over, match_winner
    );

    modport slave (
        input  game_active, round_start, p1_hit_p2, p2_hit_p1,
               p1_blocked_by_p2, p2_blocked_by_p1,
        output p1_health, p2_health, p1_block_count, p2_block_count,
               p1_in_hitstun, p2_in_hitstun, p1_in_blockstun, p2_in_blockstun,
               p1_stun_timer, p2_stun_timer, p1_rounds, p2_rounds,
               round_over, round_winner, match_over, match_winner
    );
endinterface

// File: rtl/combat_state_tracker.sv
// Per-frame health/guard/stun bookkeeping for two fighters plus round/match sequencing.
// Latency: one frame from event pulse to registered output.
// Backpressure: none; events outside FIGHT or while game_active=0 are dropped.
module combat_state_tracker #(
    parameter int MAX_HEALTH    = 3,
    parameter int HEALTH_W      = 3,
    parameter int MAX_BLOCKS    = 3,
    parameter int BLOCK_W       = 3,
    parameter int DAMAGE        = 1,
    parameter int HITSTUN       = 16,
    parameter int BLOCKSTUN     = 14,
    parameter int STUN_W        = 5,
    parameter int REGEN_FRAMES  = 120,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic                    clk_game,
    input  logic                    reset,
    combat_state_tracker_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FIGHT, ROUND_END, MATCH_END} state_t;

    localparam int REGEN_W = (REGEN_FRAMES > 0) ? $clog2(REGEN_FRAMES + 1) : 1;
    localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
    localparam logic [BLOCK_W-1:0]  BLOCK_INIT  = BLOCK_W'(MAX_BLOCKS);
    localparam logic [STUN_W-1:0]   HS_RELOAD   = STUN_W'(HITSTUN);
    localparam logic [STUN_W-1:0]   BS_RELOAD   = STUN_W'(BLOCKSTUN);
    localparam logic [REGEN_W-1:0]  REGEN_LIM   = REGEN_W'(REGEN_FRAMES);
    localparam logic [1:0]          WIN_ROUNDS  = 2'(ROUNDS_TO_WIN);

    state_t state, state_next;
    logic   load_round, end_round, decide_match, clear_match, fight_en;

    // Index 0 is P1, index 1 is P2; events are those landing on that player.
    logic [HEALTH_W-1:0] health     [2];
    logic [BLOCK_W-1:0]  block_cnt  [2];
    logic [STUN_W-1:0]   stun_timer [2];
    logic [REGEN_W-1:0]  regen_cnt  [2];
    logic [1:0]          hitstun, blockstun, hit_ev, blk_ev;
    logic [1:0]          rounds [2];
    logic                round_over_q, match_over_q;
    logic [1:0]          round_winner_q, match_winner_q;

    assign hit_ev = {bus.p1_hit_p2, bus.p2_hit_p1};
    assign blk_ev = {bus.p1_blocked_by_p2, bus.p2_blocked_by_p1};

    // FSM state register
    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control strobes; nothing advances while the game is frozen
    always_comb begin
        state_next   = state;
        load_round   = 1'b0;
        end_round    = 1'b0;
        decide_match = 1'b0;
        clear_match  = 1'b0;
        fight_en     = 1'b0;
        if (bus.game_active) begin
            case (state)
                IDLE: if (bus.round_start) begin
                    state_next = FIGHT;
                    load_round = 1'b1;
                end
                FIGHT: if (health[0] == '0 || health[1] == '0) begin
                    state_next = ROUND_END;
                    end_round  = 1'b1;
                end else begin
                    fight_en = 1'b1;
                end
                ROUND_END: if ((round_winner_q == 2'b01 && rounds[0] == WIN_ROUNDS) ||
                               (round_winner_q == 2'b10 && rounds[1] == WIN_ROUNDS)) begin
                    state_next   = MATCH_END;
                    decide_match = 1'b1;
                end else if (bus.round_start) begin
                    state_next = FIGHT;
                    load_round = 1'b1;
                end
                MATCH_END: if (bus.round_start) begin
                    state_next  = FIGHT;
                    load_round  = 1'b1;
                    clear_match = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Per-player health, guard, stun and guard-regeneration bookkeeping
    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                health[i]     <= HEALTH_INIT;
                block_cnt[i]  <= BLOCK_INIT;
                stun_timer[i] <= '0;
                regen_cnt[i]  <= '0;
                hitstun[i]    <= 1'b0;
                blockstun[i]  <= 1'b0;
            end
        end else if (load_round) begin
            for (int i = 0; i < 2; i++) begin
                health[i]     <= HEALTH_INIT;
                block_cnt[i]  <= BLOCK_INIT;
                stun_timer[i] <= '0;
                regen_cnt[i]  <= '0;
                hitstun[i]    <= 1'b0;
                blockstun[i]  <= 1'b0;
            end
        end else if (fight_en) begin
            for (int i = 0; i < 2; i++) begin
                // A block with no guard left is a guard break and lands as a hit
                if (hit_ev[i] || (blk_ev[i] && block_cnt[i] == '0)) begin
                    health[i]     <= (health[i] <= DMG) ? '0 : health[i] - DMG;
                    stun_timer[i] <= HS_RELOAD;
                    hitstun[i]    <= 1'b1;
                    blockstun[i]  <= 1'b0;
                    regen_cnt[i]  <= '0;
                end else if (blk_ev[i]) begin
                    block_cnt[i]  <= block_cnt[i] - 1'b1;
                    stun_timer[i] <= BS_RELOAD;
                    hitstun[i]    <= 1'b0;
                    blockstun[i]  <= 1'b1;
                    regen_cnt[i]  <= '0;
                end else begin
                    if (hitstun[i] || blockstun[i]) begin
                        if (stun_timer[i] != '0) begin
                            stun_timer[i] <= stun_timer[i] - 1'b1;
                        end else begin
                            hitstun[i]   <= 1'b0;
                            blockstun[i] <= 1'b0;
                        end
                    end
                    if (REGEN_FRAMES != 0 && block_cnt[i] < BLOCK_INIT) begin
                        if (regen_cnt[i] == REGEN_LIM) begin
                            block_cnt[i] <= block_cnt[i] + 1'b1;
                            regen_cnt[i] <= '0;
                        end else begin
                            regen_cnt[i] <= regen_cnt[i] + 1'b1;
                        end
                    end else begin
                        regen_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Round/match results: latched on round end, cleared by the next round_start
    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            rounds[0]      <= '0;
            rounds[1]      <= '0;
            round_over_q   <= 1'b0;
            match_over_q   <= 1'b0;
            round_winner_q <= '0;
            match_winner_q <= '0;
        end else begin
            if (end_round) begin
                round_over_q   <= 1'b1;
                round_winner_q <= {health[0] == '0, health[1] == '0};
                if (health[1] == '0 && health[0] != '0) rounds[0] <= rounds[0] + 1'b1;
                if (health[0] == '0 && health[1] != '0) rounds[1] <= rounds[1] + 1'b1;
            end
            if (decide_match) begin
                match_over_q   <= 1'b1;
                match_winner_q <= round_winner_q;
            end
            if (load_round) begin
                round_over_q   <= 1'b0;
                round_winner_q <= '0;
            end
            if (clear_match) begin
                rounds[0]      <= '0;
                rounds[1]      <= '0;
                match_over_q   <= 1'b0;
                match_winner_q <= '0;
            end
        end
    end

    assign bus.p1_health       = health[0];
    assign bus.p2_health       = health[1];
    assign bus.p1_block_count  = block_cnt[0];
    assign bus.p2_block_count  = block_cnt[1];
    assign bus.p1_in_hitstun   = hitstun[0];
    assign bus.p2_in_hitstun   = hitstun[1];
    assign bus.p1_in_blockstun = blockstun[0];
    assign bus.p2_in_blockstun = blockstun[1];
    assign bus.p1_stun_timer   = stun_timer[0];
    assign bus.p2_stun_timer   = stun_timer[1];
    assign bus.p1_rounds       = rounds[0];
    assign bus.p2_rounds       = rounds[1];
    assign bus.round_over      = round_over_q;
    assign bus.round_winner    = round_winner_q;
    assign bus.match_over      = match_over_q;
    assign bus.match_winner    = match_winner_q;
endmodule

// File: tb/tb_combat_state_tracker.sv
// Directed bench: one tracker with default parameters, one with REGEN_FRAMES=8.
// Inputs are driven and outputs sampled on the falling edge of the frame clock.
// Event vector bits: 0 p1_hit_p2, 1 p2_hit_p1, 2 p1_blocked_by_p2, 3 p2_blocked_by_p1.
module tb_combat_state_tracker;
    logic       clk_game = 1'b0;
    logic       reset    = 1'b1;
    logic       ga       = 1'b1;
    logic       rs       = 1'b0;
    logic [3:0] ev_a     = '0;
    logic [3:0] ev_b     = '0;
    int         checks   = 0;
    int         errors   = 0;
    int         cnt;

    combat_state_tracker_if #(.HEALTH_W(3), .BLOCK_W(3), .STUN_W(5)) if_a ();
    combat_state_tracker_if #(.HEALTH_W(3), .BLOCK_W(3), .STUN_W(5)) if_b ();

    assign if_a.game_active      = ga;
    assign if_a.round_start      = rs;
    assign if_a.p1_hit_p2        = ev_a[0];
    assign if_a.p2_hit_p1        = ev_a[1];
    assign if_a.p1_blocked_by_p2 = ev_a[2];
    assign if_a.p2_blocked_by_p1 = ev_a[3];
    assign if_b.game_active      = ga;
    assign if_b.round_start      = rs;
    assign if_b.p1_hit_p2        = ev_b[0];
    assign if_b.p2_hit_p1        = ev_b[1];
    assign if_b.p1_blocked_by_p2 = ev_b[2];
    assign if_b.p2_blocked_by_p1 = ev_b[3];

    combat_state_tracker dut_a (
        .clk_game (clk_game),
        .reset    (reset),
        .bus      (if_a)
    );

    combat_state_tracker #(.REGEN_FRAMES(8)) dut_b (
        .clk_game (clk_game),
        .reset    (reset),
        .bus      (if_b)
    );

    always #5 clk_game = ~clk_game;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) @(negedge clk_game);
    endtask

    task automatic pulse_a(input logic [3:0] ev);
        ev_a = ev;
        @(negedge clk_game);
        ev_a = '0;
    endtask

    task automatic pulse_b(input logic [3:0] ev);
        ev_b = ev;
        @(negedge clk_game);
        ev_b = '0;
    endtask

    task automatic start_round();
        rs = 1'b1;
        @(negedge clk_game);
        rs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        frames(3);
        chk("rst_p1_health", if_a.p1_health, 3);
        chk("rst_p2_block", if_a.p2_block_count, 3);
        chk("rst_hitstun", if_a.p1_in_hitstun, 0);
        chk("rst_timer", if_a.p2_stun_timer, 0);
        chk("rst_round_over", if_a.round_over, 0);
        chk("rst_match_over", if_a.match_over, 0);
        chk("rst_rounds", {if_a.p1_rounds, if_a.p2_rounds}, 0);
        reset = 1'b0;
        frames(1);
        start_round();

        // Guard regeneration on the REGEN_FRAMES=8 instance
        pulse_b(4'b0100);
        chk("regen_block1", if_b.p2_block_count, 2);
        frames(8);
        chk("regen_not_yet", if_b.p2_block_count, 2);
        frames(1);
        chk("regen_done", if_b.p2_block_count, 3);
        pulse_b(4'b0100);
        chk("regen_block2", if_b.p2_block_count, 2);
        frames(6);
        pulse_b(4'b0100);
        chk("regen_block3", if_b.p2_block_count, 1);
        frames(8);
        chk("regen_restart", if_b.p2_block_count, 1);
        frames(1);
        chk("regen_after_restart", if_b.p2_block_count, 2);

        // Single hit on P1: 17 frames of hitstun, timer 16 down to 0
        pulse_a(4'b0010);
        chk("hit_p1_health", if_a.p1_health, 2);
        chk("hit_blockstun", if_a.p1_in_blockstun, 0);
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (if_a.p1_in_hitstun) begin
                chk("hitstun_timer", if_a.p1_stun_timer, 16 - cnt);
                cnt++;
            end
            @(negedge clk_game);
        end
        chk("hitstun_len", cnt, 17);
        chk("timer_floor", if_a.p1_stun_timer, 0);

        // round_start during FIGHT must not reload
        start_round();
        chk("rs_in_fight", if_a.p1_health, 2);

        // Events while frozen are lost
        ga = 1'b0;
        pulse_a(4'b0001);
        ga = 1'b1;
        frames(1);
        chk("frozen_hit", if_a.p2_health, 3);

        // Four blocks on P2, the fourth is a guard break
        for (int i = 0; i < 4; i++) begin
            pulse_a(4'b0100);
            if (i == 0) begin
                chk("block_stun", if_a.p2_in_blockstun, 1);
                chk("block_timer", if_a.p2_stun_timer, 14);
            end
            if (i < 3) begin
                chk("block_count", if_a.p2_block_count, 2 - i);
                frames(19);
            end
        end
        chk("gb_count", if_a.p2_block_count, 0);
        chk("gb_health", if_a.p2_health, 2);
        chk("gb_hitstun", if_a.p2_in_hitstun, 1);
        chk("gb_blockstun", if_a.p2_in_blockstun, 0);

        // Simultaneous trades down to a draw
        pulse_a(4'b0011);
        chk("trade_p1", if_a.p1_health, 1);
        chk("trade_p2", if_a.p2_health, 1);
        pulse_a(4'b0011);
        chk("trade_zero", {if_a.p1_health, if_a.p2_health}, 0);
        chk("draw_not_yet", if_a.round_over, 0);
        frames(1);
        chk("draw_over", if_a.round_over, 1);
        chk("draw_winner", if_a.round_winner, 3);
        chk("draw_rounds", {if_a.p1_rounds, if_a.p2_rounds}, 0);
        pulse_a(4'b1000);
        chk("ignored_in_end", if_a.p1_block_count, 3);
        chk("draw_no_match", if_a.match_over, 0);

        // Round won by P1 with hits 20 frames apart
        start_round();
        chk("reload_health", {if_a.p1_health, if_a.p2_health}, 6'o33);
        chk("reload_over", if_a.round_over, 0);
        chk("reload_winner", if_a.round_winner, 0);
        chk("reload_block", if_a.p2_block_count, 3);
        for (int i = 0; i < 3; i++) begin
            pulse_a(4'b0001);
            chk("r1_p2_health", if_a.p2_health, 2 - i);
            if (i < 2) frames(19);
        end
        chk("r1_not_yet", if_a.round_over, 0);
        frames(1);
        chk("r1_over", if_a.round_over, 1);
        chk("r1_winner", if_a.round_winner, 1);
        chk("r1_p1_rounds", if_a.p1_rounds, 1);
        frames(1);
        chk("r1_no_match", if_a.match_over, 0);

        // Second P1 win decides the match
        start_round();
        pulse_a(4'b0001);
        pulse_a(4'b0001);
        pulse_a(4'b0001);
        chk("r2_p2_health", if_a.p2_health, 0);
        frames(1);
        chk("r2_over", if_a.round_over, 1);
        chk("r2_p1_rounds", if_a.p1_rounds, 2);
        chk("r2_match_not_yet", if_a.match_over, 0);
        frames(1);
        chk("match_over", if_a.match_over, 1);
        chk("match_winner", if_a.match_winner, 1);
        chk("match_round_over", if_a.round_over, 1);
        start_round();
        chk("new_rounds", {if_a.p1_rounds, if_a.p2_rounds}, 0);
        chk("new_match_over", if_a.match_over, 0);
        chk("new_match_winner", if_a.match_winner, 0);
        chk("new_round_over", if_a.round_over, 0);
        chk("new_health", if_a.p2_health, 3);
        pulse_a(4'b0001);
        chk("new_fight", if_a.p2_health, 2);

        // Asynchronous reset mid-round, then IDLE ignores events
        pulse_a(4'b0010);
        #3 reset = 1'b1;
        #1;
        chk("arst_health", {if_a.p1_health, if_a.p2_health}, 6'o33);
        chk("arst_hitstun", {if_a.p1_in_hitstun, if_a.p2_in_hitstun}, 0);
        chk("arst_timer", if_a.p1_stun_timer, 0);
        chk("arst_b_block", if_b.p2_block_count, 3);
        @(negedge clk_game);
        reset = 1'b0;
        frames(1);
        pulse_a(4'b0001);
        chk("idle_ignores", if_a.p2_health, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
